// File: rtl/mem_pkg.sv
// Shared types and defaults for the memory port arbiter.
package mem_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;

   // Arbiter FSM: idle, or waiting on the memory response for one owner.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_I = 2'd1,
      WAIT_D = 2'd2
   } state_t;

   // Which requester wins the memory port in the current IDLE cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-outstanding memory port between instruction fetch
// (read-only) and the load/store stage. Data has priority; after
// MAX_D_STREAK back-to-back data grants with fetch waiting, fetch wins once.
//
// Handshake: a request transfers in a cycle where valid && ready. Requesters
// hold valid and payload until ready; nothing is latched before acceptance.
// Response valids are single-cycle pulses with no backpressure.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_D_STREAK = 4,
   parameter int CNT_W        = 32,
   localparam int STREAK_W    = $clog2(MAX_D_STREAK + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_valid,
   output logic                i_req_ready,
   input  logic [ADDR_W-1:0]   i_req_addr,
   output logic                i_resp_valid,
   output logic [ADDR_W-1:0]   i_resp_addr,
   output logic [DATA_W-1:0]   i_resp_inst,
   input  logic                d_req_valid,
   output logic                d_req_ready,
   input  logic [ADDR_W-1:0]   d_req_addr,
   input  logic                d_req_wen,
   input  logic [DATA_W-1:0]   d_req_wdata,
   input  logic [DATA_W/8-1:0] d_req_wmask,
   output logic                d_resp_valid,
   output logic [DATA_W-1:0]   d_resp_rdata,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_rdata,
   output logic [CNT_W-1:0]    i_grant_cnt,
   output logic [CNT_W-1:0]    d_grant_cnt,
   output state_t              dbg_state,
   output logic [STREAK_W-1:0] dbg_streak
);

   state_t              state, state_nxt;
   owner_t              winner;
   logic [STREAK_W-1:0] streak;
   logic [ADDR_W-1:0]   owner_addr;
   logic                i_accept, d_accept;

   assign i_accept   = i_req_valid & i_req_ready;
   assign d_accept   = d_req_valid & d_req_ready;
   assign dbg_state  = state;
   assign dbg_streak = streak;

   // Priority pick; fetch wins over data only once the streak is exhausted.
   // Gated by rst so nothing is offered while reset is held.
   always_comb begin
      winner = OWN_NONE;
      if (!rst && state == IDLE) begin
         if (d_req_valid && !(i_req_valid && streak == STREAK_W'(MAX_D_STREAK)))
            winner = OWN_D;
         else if (i_req_valid)
            winner = OWN_I;
      end
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state: accept moves to the owner's wait state, any response returns
   // to IDLE (so a response cycle can never also accept).
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (i_accept)      state_nxt = WAIT_I;
            else if (d_accept) state_nxt = WAIT_D;
         end
         WAIT_I:  if (mem_resp_valid) state_nxt = IDLE;
         WAIT_D:  if (mem_resp_valid) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs: request mux from the winner, responses passed straight through.
   always_comb begin
      i_req_ready   = 1'b0;
      d_req_ready   = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_addr  = '0;
      mem_req_wen   = 1'b0;
      mem_req_wdata = '0;
      mem_req_wmask = '0;
      i_resp_valid  = 1'b0;
      i_resp_addr   = '0;
      i_resp_inst   = '0;
      d_resp_valid  = 1'b0;
      d_resp_rdata  = '0;
      case (winner)
         OWN_D: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = d_req_addr;
            mem_req_wen   = d_req_wen;
            mem_req_wdata = d_req_wdata;
            mem_req_wmask = d_req_wmask;
            d_req_ready   = mem_req_ready;
         end
         OWN_I: begin
            mem_req_valid = 1'b1;
            mem_req_addr  = i_req_addr;
            i_req_ready   = mem_req_ready;
         end
         default: ;
      endcase
      if (!rst && state == WAIT_I && mem_resp_valid) begin
         i_resp_valid = 1'b1;
         i_resp_addr  = owner_addr;
         i_resp_inst  = mem_resp_rdata;
      end
      if (!rst && state == WAIT_D && mem_resp_valid) begin
         d_resp_valid = 1'b1;
         d_resp_rdata = mem_resp_rdata;
      end
   end

   // Streak, fetch address and grant counters update only on an accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak      <= '0;
         owner_addr  <= '0;
         i_grant_cnt <= '0;
         d_grant_cnt <= '0;
      end else if (d_accept) begin
         d_grant_cnt <= d_grant_cnt + CNT_W'(1);
         if (!i_req_valid)
            streak <= '0;
         else if (streak != STREAK_W'(MAX_D_STREAK))
            streak <= streak + STREAK_W'(1);
      end else if (i_accept) begin
         i_grant_cnt <= i_grant_cnt + CNT_W'(1);
         owner_addr  <= i_req_addr;
         streak      <= '0;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch-only, simultaneous requests,
// starvation bound, masked store, backpressure with stray response, and
// reset in the middle of a data transaction.
module tb_mem_arbiter;
   import mem_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int MAXS   = 4;
   localparam int CNT_W  = 32;
   localparam int SW     = $clog2(MAXS + 1);

   logic                clk = 1'b0;
   logic                rst;
   logic                i_req_valid, i_req_ready;
   logic [ADDR_W-1:0]   i_req_addr;
   logic                i_resp_valid;
   logic [ADDR_W-1:0]   i_resp_addr;
   logic [DATA_W-1:0]   i_resp_inst;
   logic                d_req_valid, d_req_ready;
   logic [ADDR_W-1:0]   d_req_addr;
   logic                d_req_wen;
   logic [DATA_W-1:0]   d_req_wdata;
   logic [DATA_W/8-1:0] d_req_wmask;
   logic                d_resp_valid;
   logic [DATA_W-1:0]   d_resp_rdata;
   logic                mem_req_valid, mem_req_ready;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_req_wen;
   logic [DATA_W-1:0]   mem_req_wdata;
   logic [DATA_W/8-1:0] mem_req_wmask;
   logic                mem_resp_valid;
   logic [DATA_W-1:0]   mem_resp_rdata;
   logic [CNT_W-1:0]    i_grant_cnt, d_grant_cnt;
   state_t              dbg_state;
   logic [SW-1:0]       dbg_streak;

   int tests = 0;
   int fails = 0;

   mem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_D_STREAK(MAXS), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
      .i_resp_valid(i_resp_valid), .i_resp_addr(i_resp_addr), .i_resp_inst(i_resp_inst),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
      .d_req_wen(d_req_wen), .d_req_wdata(d_req_wdata), .d_req_wmask(d_req_wmask),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
      .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata),
      .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
      .dbg_state(dbg_state), .dbg_streak(dbg_streak)
   );

   // Clock: 10 time-unit period.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Move to 1 unit after the next rising edge; inputs are driven here and
   // checks follow a further #1 once combinational outputs settle.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   bit [5:0] order;
   int       s_tab [6];

   initial begin
      rst = 1'b1;
      i_req_valid = 1'b1; i_req_addr = 32'h0;
      d_req_valid = 1'b1; d_req_addr = 32'h0; d_req_wen = 1'b0;
      d_req_wdata = '0; d_req_wmask = '0;
      mem_req_ready = 1'b1; mem_resp_valid = 1'b0; mem_resp_rdata = '0;
      order = 6'b101111;
      s_tab = '{1, 2, 3, 4, 0, 1};

      // ---- reset state: requests asserted but nothing offered
      step(); settle();
      check("rst_i_ready", i_req_ready, 0);
      check("rst_d_ready", d_req_ready, 0);
      check("rst_mem_valid", mem_req_valid, 0);
      check("rst_state", dbg_state, IDLE);
      check("rst_i_cnt", i_grant_cnt, 0);
      check("rst_d_cnt", d_grant_cnt, 0);
      check("rst_streak", dbg_streak, 0);

      // ---- fetch only: accept at T, response at T+2
      step();
      rst = 1'b0; d_req_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h100;
      settle();
      check("f_i_ready", i_req_ready, 1);
      check("f_mem_valid", mem_req_valid, 1);
      check("f_mem_addr", mem_req_addr, 32'h100);
      check("f_mem_wen", mem_req_wen, 0);
      step();
      i_req_valid = 1'b0; settle();
      check("f_state_wait", dbg_state, WAIT_I);
      check("f_no_resp_early", i_resp_valid, 0);
      check("f_i_cnt", i_grant_cnt, 1);
      check("f_mem_idle", mem_req_valid, 0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0013; settle();
      check("f_resp_valid", i_resp_valid, 1);
      check("f_resp_addr", i_resp_addr, 32'h100);
      check("f_resp_inst", i_resp_inst, 32'h13);
      check("f_d_untouched", d_resp_valid, 0);
      step();
      mem_resp_valid = 1'b0; settle();
      check("f_back_idle", dbg_state, IDLE);
      check("f_resp_zero", i_resp_inst, 0);

      // ---- simultaneous: data wins, fetch follows right after the response
      i_req_valid = 1'b1; i_req_addr = 32'h200;
      d_req_valid = 1'b1; d_req_addr = 32'h1000; d_req_wen = 1'b0;
      settle();
      check("s_d_ready", d_req_ready, 1);
      check("s_i_ready", i_req_ready, 0);
      check("s_mem_addr", mem_req_addr, 32'h1000);
      step();
      d_req_valid = 1'b0; settle();
      check("s_state_wd", dbg_state, WAIT_D);
      check("s_streak1", dbg_streak, 1);
      check("s_i_blocked", i_req_ready, 0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'hCAFE_F00D; settle();
      check("s_d_resp", d_resp_valid, 1);
      check("s_d_rdata", d_resp_rdata, 32'hCAFE_F00D);
      check("s_no_acc_resp", i_req_ready, 0);
      step();
      mem_resp_valid = 1'b0; settle();
      check("s_i_ready_next", i_req_ready, 1);
      check("s_mem_addr_i", mem_req_addr, 32'h200);
      step();
      i_req_valid = 1'b0; settle();
      check("s_i_cnt", i_grant_cnt, 2);
      check("s_d_cnt", d_grant_cnt, 1);
      check("s_streak0", dbg_streak, 0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0093; settle();
      check("s_i_resp_addr", i_resp_addr, 32'h200);
      check("s_i_resp_inst", i_resp_inst, 32'h93);
      step();
      mem_resp_valid = 1'b0;

      // ---- starvation bound: D D D D I D with both held, 1-cycle memory
      i_req_valid = 1'b1; i_req_addr = 32'h300;
      d_req_valid = 1'b1; d_req_addr = 32'h1100;
      for (int k = 0; k < 6; k++) begin
         settle();
         check($sformatf("st_d_ready_%0d", k), d_req_ready, order[k]);
         check($sformatf("st_i_ready_%0d", k), i_req_ready, !order[k]);
         step();
         mem_resp_valid = 1'b1; mem_resp_rdata = 32'h1000 + k;
         settle();
         check($sformatf("st_streak_%0d", k), dbg_streak, s_tab[k]);
         check($sformatf("st_resp_%0d", k), order[k] ? d_resp_valid : i_resp_valid, 1);
         step();
         mem_resp_valid = 1'b0;
      end
      i_req_valid = 1'b0; d_req_valid = 1'b0;
      settle();
      check("st_i_cnt", i_grant_cnt, 3);
      check("st_d_cnt", d_grant_cnt, 6);

      // ---- masked store
      d_req_valid = 1'b1; d_req_addr = 32'h2000; d_req_wen = 1'b1;
      d_req_wdata = 32'hDEAD_BEEF; d_req_wmask = 4'b0011;
      settle();
      check("w_d_ready", d_req_ready, 1);
      check("w_mem_wen", mem_req_wen, 1);
      check("w_mem_wmask", mem_req_wmask, 4'b0011);
      check("w_mem_wdata", mem_req_wdata, 32'hDEAD_BEEF);
      check("w_mem_addr", mem_req_addr, 32'h2000);
      step();
      d_req_valid = 1'b0; d_req_wen = 1'b0; settle();
      check("w_streak0", dbg_streak, 0);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h55; settle();
      check("w_d_resp", d_resp_valid, 1);
      check("w_i_quiet", i_resp_valid, 0);
      step();
      mem_resp_valid = 1'b0; settle();
      check("w_d_cnt", d_grant_cnt, 7);
      check("w_i_cnt", i_grant_cnt, 3);

      // ---- backpressure with a stray response in IDLE
      mem_req_ready = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h300;
      for (int k = 0; k < 3; k++) begin
         mem_resp_valid = (k == 1);
         settle();
         check($sformatf("bp_i_ready_%0d", k), i_req_ready, 0);
         check($sformatf("bp_mem_valid_%0d", k), mem_req_valid, 1);
         check($sformatf("bp_i_resp_%0d", k), i_resp_valid, 0);
         check($sformatf("bp_d_resp_%0d", k), d_resp_valid, 0);
         step();
      end
      mem_resp_valid = 1'b0; i_req_valid = 1'b0; mem_req_ready = 1'b1;
      settle();
      check("bp_state", dbg_state, IDLE);
      check("bp_i_cnt", i_grant_cnt, 3);
      check("bp_d_cnt", d_grant_cnt, 7);

      // ---- reset while waiting on a data response
      d_req_valid = 1'b1; d_req_addr = 32'h1004;
      settle();
      check("r_d_ready", d_req_ready, 1);
      step();
      settle();
      check("r_state_wd", dbg_state, WAIT_D);
      rst = 1'b1; i_req_valid = 1'b1; i_req_addr = 32'h400;
      settle();
      check("r_in_state", dbg_state, IDLE);
      check("r_in_d_ready", d_req_ready, 0);
      check("r_in_i_ready", i_req_ready, 0);
      check("r_in_mem_valid", mem_req_valid, 0);
      check("r_in_i_cnt", i_grant_cnt, 0);
      check("r_in_d_cnt", d_grant_cnt, 0);
      step();
      rst = 1'b0; i_req_valid = 1'b0; d_req_valid = 1'b0;
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h7777_7777; settle();
      check("r_no_d_resp", d_resp_valid, 0);
      check("r_d_rdata_zero", d_resp_rdata, 0);
      step();
      mem_resp_valid = 1'b0; i_req_valid = 1'b1; i_req_addr = 32'h400;
      settle();
      check("r_i_ready", i_req_ready, 1);
      step();
      i_req_valid = 1'b0; settle();
      check("r_i_cnt", i_grant_cnt, 1);
      check("r_state_wi", dbg_state, WAIT_I);
      step();
      mem_resp_valid = 1'b1; mem_resp_rdata = 32'h0000_0033; settle();
      check("r_i_resp_addr", i_resp_addr, 32'h400);
      check("r_i_resp_valid", i_resp_valid, 1);
      step();
      mem_resp_valid = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
